// File: rtl/par_delay_line.sv
// Tap-selectable, clock-enabled delay line with saturating fill tracking.
// Optional macro PAR_DELAY_LINE_OUT_REG_EN registers out/valid (one extra clock of latency).
module par_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             flush,
  input  logic [SEL_W-1:0] tap,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [SEL_W:0]   fill
);

  localparam logic [SEL_W-1:0] MAX_TAP  = SEL_W'(DEPTH - 1);
  localparam logic [SEL_W:0]   FILL_MAX = (SEL_W + 1)'(DEPTH);
  localparam logic [SEL_W:0]   FILL_ONE = (SEL_W + 1)'(1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [SEL_W:0]   fill_q;
  logic [SEL_W-1:0] eff_tap;
  logic [WIDTH-1:0] out_c;
  logic             valid_c;

  // Flush shares the reset path; a concurrent ce is deliberately dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
      fill_q <= '0;
    end else if (ce) begin
      stage[0] <= in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + FILL_ONE;
      end
    end
  end

  // Out-of-range taps clamp to the last stage so storage is never over-indexed.
  always_comb begin
    eff_tap = tap;
    if (tap > MAX_TAP) begin
      eff_tap = MAX_TAP;
    end
  end

  always_comb begin
    out_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (eff_tap == SEL_W'(i)) begin
        out_c = stage[i];
      end
    end
    valid_c = (fill_q > {1'b0, eff_tap});
  end

  assign fill = fill_q;

`ifdef PAR_DELAY_LINE_OUT_REG_EN
  logic [WIDTH-1:0] out_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_c;
      valid_q <= valid_c;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
`else
  assign out   = out_c;
  assign valid = valid_c;
`endif

endmodule

// File: doc/par_delay_line.md
# par_delay_line

Parametrised, clock-enabled delay line with a run-time selectable tap and fill tracking. It holds up to DEPTH WIDTH-bit samples. Each `ce` pulse shifts one sample in. The output is taken from the stage chosen by `tap`, giving a delay of 1..DEPTH `ce` events, and is qualified by `valid`. It sits in the delay_line subsystem wherever a fixed single-stage enabled latch is not enough, for example in pixel/neighbourhood alignment for LBP windows.

## Interface
- `WIDTH`, default 8: sample width in bits.
- `DEPTH`, default 16: number of stages; legal range 2..256.
- `SEL_W`, default 4: width of `tap`; must satisfy 2^SEL_W >= DEPTH.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `ce` input, 1 bit: shift enable, one sample accepted per cycle with `ce`=1.
- `flush` input, 1 bit: synchronous clear of stored data and fill state.
- `tap` input, SEL_W bits: selected stage index; delay = tap+1 `ce` events.
- `in` input, WIDTH bits: sample shifted into stage 0.
- `out` output, WIDTH bits: content of the selected stage.
- `valid` output, 1 bit: the selected stage holds a sample written since the last reset/flush.
- `fill` output, SEL_W+1 bits: number of samples accepted since reset/flush, saturating at DEPTH.

## Operation
- Storage: stages s[0..DEPTH-1], each WIDTH bits. Counter `fill` ranges 0..DEPTH.
- Priority per clock edge, highest first: `rst_n`=0, then `flush`=1, then `ce`=1, then hold.
- Reset (`rst_n`=0): all stages go to 0 and `fill` goes to 0. `ce` and `flush` are ignored.
- Flush: same effect as reset. A simultaneous `ce` is dropped; the sample on `in` is lost.
- Shift (`ce`=1): s[0] <= in and s[k] <= s[k-1] for k = 1..DEPTH-1. `fill` <= min(fill+1, DEPTH).
- Hold (`ce`=0): all state is unchanged.
- Tap clamp: effective tap = min(tap, DEPTH-1). An out-of-range tap never selects undefined storage.
- `out` = s[effective tap].
- `valid` = (fill > effective tap).
- Wrap-around: none. The oldest sample falls off s[DEPTH-1]. Once `fill` saturates it stays at DEPTH until reset/flush.
- A `tap` change takes effect on `out`/`valid` with no state disturbance. No data is lost or reordered.

## Timing
- Outputs are combinational from stage registers and `tap`.
- A sample presented with `ce` at edge N appears in s[0] after edge N. With `tap`=k it appears on `out` after the (k+1)-th `ce` edge, counting edge N as the first.
- `valid` rises in the same cycle the sample first appears on `out`.
- After any reset or flush, `out`=0, `valid`=0 and `fill`=0 from the following cycle until new `ce` events occur.
- With `ce` held high and `tap`=k, latency is exactly k+1 clocks.
- With `ce` gapped, latency is k+1 `ce` events; idle cycles do not age data.

## Configuration
- Macro: `PAR_DELAY_LINE_OUT_REG_EN`.
- Defined:
  - `out` and `valid` are registered, updated every clock from the combinational values above.
  - Latency is one extra clock: tap+2 clocks with continuous `ce`.
  - A `tap` change is visible after one clock.
  - Both output registers reset/flush to 0.
  - `fill` stays combinational from the counter.
- Not defined: outputs are combinational exactly as in Operation/Timing.

## Test plan
- Reset check: drive `rst_n`=0 with `ce`=1 and `in`=8'hAA for 3 clocks, then release. Expect `out`=0, `valid`=0, `fill`=0, with no shift while in reset.
- Continuous shift: `tap`=3, `ce`=1, `in`=1,2,3,... on successive clocks. Expect `valid` to rise after the 4th edge with `out`=1, then `out` increments by 1 per clock. `fill` saturates at 16 and holds.
- Gapped enable: `tap`=1, feed 8'h10 and 8'h20 with `ce` separated by 5 idle cycles. Expect `out`=8'h10 and `valid`=1 only after the second `ce` edge. `out` stays constant through the idle cycles.
- Tap sweep and clamp: fill 16 samples 0..15, hold `ce`=0, then step `tap` from 0 to 15. Expect `out`=15-tap. With SEL_W=5, DEPTH=16 and `tap`=20, expect `out`=0 (stage 15) and `valid`=1.
- Flush priority: with `fill`=16, assert `flush` and `ce` together with `in`=8'h55. Expect `fill`=0, `out`=0 and `valid`=0 next cycle, and 8'h55 never appears.
- With `PAR_DELAY_LINE_OUT_REG_EN` defined: repeat the continuous-shift test. Expect first `valid` and `out`=1 one clock later than without the macro (after the 5th edge).
